// File: rtl/aes_key_expand.sv
// Iterative AES-128 key schedule: emits round keys 0..10, one per accepted
// valid/ready transfer, with SubWord built from four combinational S-boxes.

module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] s
);
  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] p;
    logic [7:0] v;
    p = 8'h00;
    v = x;
    for (int i = 0; i < 8; i++) begin
      if (y[i]) p = p ^ v;
      v = xtime(v);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254; zero maps to zero naturally.
  function automatic logic [7:0] ginv(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] acc;
    sq  = gmul(x, x);
    acc = sq;
    for (int i = 0; i < 6; i++) begin
      sq  = gmul(sq, sq);
      acc = gmul(acc, sq);
    end
    return acc;
  endfunction

  function automatic logic [7:0] affine(input logic [7:0] b);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
             ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  assign s = affine(ginv(a));
endmodule

// Handshake: a round key transfers on any rising edge where o_rkey_valid and
// i_ready are both high; o_rkey/o_rnd hold steady while valid waits for ready.
module aes_key_expand (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_start,
  input  logic [127:0] i_key,
  input  logic         i_ready,
  output logic [127:0] o_rkey,
  output logic [3:0]   o_rnd,
  output logic         o_rkey_valid,
  output logic         o_busy,
  output logic         o_done
);
  typedef enum logic {IDLE = 1'b0, EMIT = 1'b1} state_t;

  state_t       state_q, state_d;
  logic [127:0] w_q, w_d;
  logic [3:0]   rnd_q, rnd_d;
  logic         done_q, done_d;

  logic [3:0]   rnd_gen;
  logic [7:0]   rcon;
  logic [31:0]  rot_w3;
  logic [31:0]  sub_w3;
  logic [31:0]  t;
  logic [31:0]  n0, n1, n2, n3;

  assign rnd_gen = rnd_q + 4'd1;

  always_comb begin
    rcon = 8'h00;
    case (rnd_gen)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end

  assign rot_w3 = {w_q[23:0], w_q[31:24]};

  aes_sbox u_sbox0 (.a(rot_w3[31:24]), .s(sub_w3[31:24]));
  aes_sbox u_sbox1 (.a(rot_w3[23:16]), .s(sub_w3[23:16]));
  aes_sbox u_sbox2 (.a(rot_w3[15:8]),  .s(sub_w3[15:8]));
  aes_sbox u_sbox3 (.a(rot_w3[7:0]),   .s(sub_w3[7:0]));

  assign t  = sub_w3 ^ {rcon, 24'h000000};
  assign n0 = w_q[127:96] ^ t;
  assign n1 = w_q[95:64]  ^ n0;
  assign n2 = w_q[63:32]  ^ n1;
  assign n3 = w_q[31:0]   ^ n2;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      w_q     <= '0;
      rnd_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      rnd_q   <= rnd_d;
      done_q  <= done_d;
    end
  end

  // The o_done cycle still counts as busy, so a start there is dropped.
  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    rnd_d   = rnd_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_start && !done_q) begin
          w_d     = i_key;
          rnd_d   = 4'd0;
          state_d = EMIT;
        end
      end
      EMIT: begin
        if (i_ready) begin
          if (rnd_q == 4'd10) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            w_d   = {n0, n1, n2, n3};
            rnd_d = rnd_gen;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign o_rkey       = w_q;
  assign o_rnd        = rnd_q;
  assign o_rkey_valid = (state_q == EMIT);
  assign o_busy       = (state_q == EMIT) || done_q;
  assign o_done       = done_q;
endmodule
